// File: rtl/mod_n_counter_pkg.sv
// Shared constants and types for the modulo-N up/down counter.
package mod_n_counter_pkg;

   localparam int MODULUS_MIN = 2;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // Legal modulus spans 2 .. 2**width inclusive.
   function automatic bit modulus_ok(input int width, input int modulus);
      return (modulus >= MODULUS_MIN) && (modulus <= (1 << width));
   endfunction

endpackage

// File: rtl/mod_n_counter_if.sv
// Control and status bundle of the modulo-N counter; master drives, slave counts.
interface mod_n_counter_if #(
   parameter int WIDTH = 4
);
   logic             step;
   logic             up;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count;
   logic             wrap;
   logic             carry;
   logic             overflow;

   modport master (
      output step, up, clear, load, load_value,
      input  count, wrap, carry, overflow
   );

   modport slave (
      input  step, up, clear, load, load_value,
      output count, wrap, carry, overflow
   );
endinterface

// File: rtl/mod_n_counter_pulse_sync.sv
// Two-flop synchroniser followed by a rising-edge detector giving a one-cycle pulse.
module pulse_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic pulse_o
);
   logic       meta_q, sync_q, prev_q, armed_q;
   logic [1:0] prime_q;

   // The detector only arms once the synchronised input has been seen low after
   // reset, so a level already high at release is never mistaken for a press.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         prev_q  <= 1'b0;
         prime_q <= 2'b00;
         armed_q <= 1'b0;
      end else begin
         // NOTE: non-blocking for every flop so the chain shifts one stage per edge.
         meta_q  <= async_i;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         prime_q <= {prime_q[0], 1'b1};
         armed_q <= armed_q | (prime_q[1] & ~sync_q);
      end
   end

   assign pulse_o = armed_q & sync_q & ~prev_q;

endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with clear, clamped load, wrap/saturate and cascade carry.
module mod_n_counter
   import mod_n_counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 10,
   parameter int SATURATE  = 0,
   parameter int SYNC_STEP = 1
) (
   input logic           clk_i,
   input logic           rst_ni,
   mod_n_counter_if.slave bus
);
   if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("mod_n_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
   end

   localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 1);

   logic             advance;
   logic             count_up;
   logic             at_term;
   logic [WIDTH:0]   count_x;
   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;

   if (SYNC_STEP != 0) begin : g_sync_step
      pulse_sync u_pulse_sync (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .async_i (bus.step),
         .pulse_o (advance)
      );
   end else begin : g_level_step
      assign advance = bus.step;
   end

   // Arithmetic is one bit wider so MODULUS = 2**WIDTH compares without truncation.
   assign count_x  = {1'b0, count_q};
   assign count_up = (dir_e'(bus.up) == DIR_UP);
   assign at_term  = count_up ? (count_x == MAX_X) : (count_x == '0);

   always_comb begin
      // NOTE: defaults first, so every path assigns every signal and no latch appears.
      count_d = count_q;
      wrap_d  = 1'b0;
      ovf_d   = ovf_q;
      if (bus.clear) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (bus.load) begin
         count_d = ({1'b0, bus.load_value} > MAX_X) ? MAX_W : bus.load_value;
      end else if (advance) begin
         if (!at_term) begin
            count_d = count_up ? WIDTH'(count_x + ONE_X) : WIDTH'(count_x - ONE_X);
         end else if (SATURATE != 0) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_up ? '0 : MAX_W;
            wrap_d  = 1'b1;
            ovf_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.wrap     = wrap_q;
   assign bus.overflow = ovf_q;
   assign bus.carry    = advance & at_term;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench: three counters (wrap+edge, saturate+edge, wrap+level) on one clock.
module tb_mod_n_counter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails  = 0;
   int   wraps_a = 0;
   int   wraps_b = 0;
   int   w0;

   always #5 clk = ~clk;

   mod_n_counter_if #(.WIDTH(4)) ifa ();
   mod_n_counter_if #(.WIDTH(4)) ifb ();
   mod_n_counter_if #(.WIDTH(4)) ifc ();

   mod_n_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .SYNC_STEP(1)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .bus(ifa));
   mod_n_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .SYNC_STEP(1)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .bus(ifb));
   mod_n_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .SYNC_STEP(0)) u_dut_c (
      .clk_i(clk), .rst_ni(rst_n), .bus(ifc));

   always @(negedge clk) begin
      if (ifa.wrap) wraps_a++;
      if (ifb.wrap) wraps_b++;
   end

   // Tasks are entered and left at a falling edge.
   task automatic press_a(input int hold);
      ifa.step = 1'b1;
      repeat (hold) @(negedge clk);
      ifa.step = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic press_b(input int hold);
      ifb.step = 1'b1;
      repeat (hold) @(negedge clk);
      ifb.step = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset;
      checks++; if (ifa.count !== 4'd0) begin fails++; $display("FAIL reset_count_a: got %0d want 0", ifa.count); end
      checks++; if (ifa.wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap_a: got %b want 0", ifa.wrap); end
      checks++; if (ifa.overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf_a: got %b want 0", ifa.overflow); end
      checks++; if (ifa.carry !== 1'b0) begin fails++; $display("FAIL reset_carry_a: got %b want 0", ifa.carry); end
      checks++; if (ifb.count !== 4'd0) begin fails++; $display("FAIL reset_count_b: got %0d want 0", ifb.count); end
      checks++; if (ifc.count !== 4'd0) begin fails++; $display("FAIL reset_count_c: got %0d want 0", ifc.count); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      ifa.load_value = 4'd7;
      ifa.load = 1'b1;
      @(negedge clk);
      ifa.load = 1'b0;
      checks++; if (ifa.count !== 4'd7) begin fails++; $display("FAIL load_plain: got %0d want 7", ifa.count); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (ifa.count !== 4'd0) begin fails++; $display("FAIL reset_async: got %0d want 0", ifa.count); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_up_wrap;
      ifa.up = 1'b1;
      w0 = wraps_a;
      for (int i = 1; i <= 10; i++) begin
         press_a(2);
         checks++; if (ifa.count !== 4'(i % 10)) begin fails++; $display("FAIL up_count[%0d]: got %0d want %0d", i, ifa.count, i % 10); end
         if (i == 9) begin
            checks++; if (ifa.overflow !== 1'b0) begin fails++; $display("FAIL up_ovf_early: got %b want 0", ifa.overflow); end
         end
      end
      checks++; if (wraps_a - w0 !== 1) begin fails++; $display("FAIL up_wrap_pulses: got %0d want 1", wraps_a - w0); end
      checks++; if (ifa.overflow !== 1'b1) begin fails++; $display("FAIL up_ovf: got %b want 1", ifa.overflow); end
   endtask

   task automatic test_down_wrap;
      ifa.clear = 1'b1;
      @(negedge clk);
      ifa.clear = 1'b0;
      checks++; if (ifa.count !== 4'd0) begin fails++; $display("FAIL clear_count: got %0d want 0", ifa.count); end
      checks++; if (ifa.overflow !== 1'b0) begin fails++; $display("FAIL clear_ovf: got %b want 0", ifa.overflow); end
      ifa.up = 1'b0;
      w0 = wraps_a;
      ifa.step = 1'b1;
      @(negedge clk);
      checks++; if (ifa.carry !== 1'b0) begin fails++; $display("FAIL down_carry_early: got %b want 0", ifa.carry); end
      @(negedge clk);
      checks++; if (ifa.carry !== 1'b1) begin fails++; $display("FAIL down_carry: got %b want 1", ifa.carry); end
      checks++; if (ifa.count !== 4'd0) begin fails++; $display("FAIL down_latency: got %0d want 0", ifa.count); end
      ifa.step = 1'b0;
      @(negedge clk);
      checks++; if (ifa.count !== 4'd9) begin fails++; $display("FAIL down_wrap_count: got %0d want 9", ifa.count); end
      checks++; if (ifa.wrap !== 1'b1) begin fails++; $display("FAIL down_wrap_pulse: got %b want 1", ifa.wrap); end
      repeat (3) @(negedge clk);
      checks++; if (wraps_a - w0 !== 1) begin fails++; $display("FAIL down_wrap_once: got %0d want 1", wraps_a - w0); end
      checks++; if (ifa.overflow !== 1'b1) begin fails++; $display("FAIL down_ovf: got %b want 1", ifa.overflow); end
      press_a(2);
      checks++; if (ifa.count !== 4'd8) begin fails++; $display("FAIL down_dec: got %0d want 8", ifa.count); end
   endtask

   task automatic test_load;
      ifa.load_value = 4'd13;
      ifa.load = 1'b1;
      @(negedge clk);
      ifa.load = 1'b0;
      checks++; if (ifa.count !== 4'd9) begin fails++; $display("FAIL load_clamp: got %0d want 9", ifa.count); end
      checks++; if (ifa.overflow !== 1'b1) begin fails++; $display("FAIL load_keeps_ovf: got %b want 1", ifa.overflow); end
      ifa.load_value = 4'd3;
      ifa.load = 1'b1;
      ifa.clear = 1'b1;
      @(negedge clk);
      ifa.load = 1'b0;
      ifa.clear = 1'b0;
      checks++; if (ifa.count !== 4'd0) begin fails++; $display("FAIL clear_over_load: got %0d want 0", ifa.count); end
      checks++; if (ifa.overflow !== 1'b0) begin fails++; $display("FAIL clear_over_load_ovf: got %b want 0", ifa.overflow); end
      // Load at the up terminal held across a press: no step, no wrap, no overflow.
      ifa.up = 1'b1;
      ifa.load_value = 4'd9;
      ifa.load = 1'b1;
      w0 = wraps_a;
      press_a(2);
      ifa.load = 1'b0;
      checks++; if (ifa.count !== 4'd9) begin fails++; $display("FAIL load_over_step: got %0d want 9", ifa.count); end
      checks++; if (wraps_a - w0 !== 0) begin fails++; $display("FAIL load_over_step_wrap: got %0d want 0", wraps_a - w0); end
      checks++; if (ifa.overflow !== 1'b0) begin fails++; $display("FAIL load_over_step_ovf: got %b want 0", ifa.overflow); end
      ifa.load_value = 4'd4;
      ifa.load = 1'b1;
      @(negedge clk);
      ifa.load = 1'b0;
      press_a(2);
      checks++; if (ifa.count !== 4'd5) begin fails++; $display("FAIL step_after_load: got %0d want 5", ifa.count); end
   endtask

   task automatic test_held;
      ifa.clear = 1'b1;
      @(negedge clk);
      ifa.clear = 1'b0;
      ifa.up = 1'b1;
      ifa.step = 1'b1;
      @(negedge clk);
      checks++; if (ifa.count !== 4'd0) begin fails++; $display("FAIL held_edge1: got %0d want 0", ifa.count); end
      @(negedge clk);
      checks++; if (ifa.count !== 4'd0) begin fails++; $display("FAIL held_edge2: got %0d want 0", ifa.count); end
      @(negedge clk);
      checks++; if (ifa.count !== 4'd1) begin fails++; $display("FAIL held_edge3: got %0d want 1", ifa.count); end
      repeat (47) @(negedge clk);
      checks++; if (ifa.count !== 4'd1) begin fails++; $display("FAIL held_50: got %0d want 1", ifa.count); end
      ifa.step = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (ifa.count !== 4'd1) begin fails++; $display("FAIL held_release: got %0d want 1", ifa.count); end
   endtask

   task automatic test_reset_mid_press;
      ifa.load_value = 4'd5;
      ifa.load = 1'b1;
      @(negedge clk);
      ifa.load = 1'b0;
      w0 = wraps_a;
      ifa.step = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ifa.count !== 4'd0) begin fails++; $display("FAIL midpress_in_reset: got %0d want 0", ifa.count); end
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      checks++; if (ifa.count !== 4'd0) begin fails++; $display("FAIL midpress_no_advance: got %0d want 0", ifa.count); end
      checks++; if (ifa.overflow !== 1'b0) begin fails++; $display("FAIL midpress_ovf: got %b want 0", ifa.overflow); end
      checks++; if (wraps_a - w0 !== 0) begin fails++; $display("FAIL midpress_wrap: got %0d want 0", wraps_a - w0); end
      ifa.step = 1'b0;
      repeat (4) @(negedge clk);
      press_a(2);
      checks++; if (ifa.count !== 4'd1) begin fails++; $display("FAIL midpress_next_press: got %0d want 1", ifa.count); end
   endtask

   task automatic test_saturate;
      ifb.load_value = 4'd9;
      ifb.load = 1'b1;
      @(negedge clk);
      ifb.load = 1'b0;
      ifb.up = 1'b1;
      w0 = wraps_b;
      for (int i = 0; i < 3; i++) begin
         press_b(2);
         checks++; if (ifb.count !== 4'd9) begin fails++; $display("FAIL sat_up[%0d]: got %0d want 9", i, ifb.count); end
      end
      checks++; if (wraps_b - w0 !== 0) begin fails++; $display("FAIL sat_up_wrap: got %0d want 0", wraps_b - w0); end
      checks++; if (ifb.overflow !== 1'b1) begin fails++; $display("FAIL sat_up_ovf: got %b want 1", ifb.overflow); end
      ifb.clear = 1'b1;
      @(negedge clk);
      ifb.clear = 1'b0;
      ifb.up = 1'b0;
      press_b(2);
      checks++; if (ifb.count !== 4'd0) begin fails++; $display("FAIL sat_down: got %0d want 0", ifb.count); end
      checks++; if (ifb.overflow !== 1'b1) begin fails++; $display("FAIL sat_down_ovf: got %b want 1", ifb.overflow); end
      checks++; if (wraps_b - w0 !== 0) begin fails++; $display("FAIL sat_down_wrap: got %0d want 0", wraps_b - w0); end
   endtask

   task automatic test_level;
      ifc.clear = 1'b1;
      @(negedge clk);
      ifc.clear = 1'b0;
      ifc.up = 1'b1;
      ifc.step = 1'b1;
      repeat (5) @(negedge clk);
      ifc.step = 1'b0;
      checks++; if (ifc.count !== 4'd5) begin fails++; $display("FAIL level_5: got %0d want 5", ifc.count); end
      @(negedge clk);
      checks++; if (ifc.count !== 4'd5) begin fails++; $display("FAIL level_hold: got %0d want 5", ifc.count); end
      ifc.load_value = 4'd9;
      ifc.load = 1'b1;
      @(negedge clk);
      ifc.load = 1'b0;
      checks++; if (ifc.carry !== 1'b0) begin fails++; $display("FAIL level_carry_idle: got %b want 0", ifc.carry); end
      ifc.step = 1'b1;
      #1;
      checks++; if (ifc.carry !== 1'b1) begin fails++; $display("FAIL level_carry: got %b want 1", ifc.carry); end
      @(negedge clk);
      ifc.step = 1'b0;
      checks++; if (ifc.count !== 4'd0) begin fails++; $display("FAIL level_wrap_count: got %0d want 0", ifc.count); end
      checks++; if (ifc.wrap !== 1'b1) begin fails++; $display("FAIL level_wrap_pulse: got %b want 1", ifc.wrap); end
      @(negedge clk);
      checks++; if (ifc.wrap !== 1'b0) begin fails++; $display("FAIL level_wrap_one_cycle: got %b want 0", ifc.wrap); end
   endtask

   initial begin
      {ifa.step, ifa.up, ifa.clear, ifa.load} = '0;
      {ifb.step, ifb.up, ifb.clear, ifb.load} = '0;
      {ifc.step, ifc.up, ifc.clear, ifc.load} = '0;
      ifa.load_value = '0;
      ifb.load_value = '0;
      ifc.load_value = '0;
      repeat (3) @(negedge clk);
      test_reset;
      test_up_wrap;
      test_down_wrap;
      test_load;
      test_held;
      test_reset_mid_press;
      test_saturate;
      test_level;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mod_n_counter.md
MOD_N_COUNTER -- requirements
Module: mod_n_counter

Interface
REQ-001 Parameter WIDTH, default 4, count register width in bits.
REQ-002 Parameter MODULUS, default 10, count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at the limits, 1 = hold at the limits.
REQ-004 Parameter SYNC_STEP, default 1; 1 = step is asynchronous and edge-detected, 0 = step is a synchronous level.
REQ-005 clock  input  1  single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 step  input  1  advance request (a button in the board top).
REQ-008 up  input  1  direction: 1 = count up, 0 = count down; synchronous.
REQ-009 clear  input  1  synchronous clear to 0.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_value  input  WIDTH  value applied on load.
REQ-012 count  output  WIDTH  current count, registered.
REQ-013 wrap  output  1  one-cycle pulse, registered, in the cycle after count wraps.
REQ-014 carry  output  1  combinational: advance AND count at the terminal value for the current direction, for cascading.
REQ-015 overflow  output  1  sticky flag, registered.

Function
REQ-016 advance = step_pulse when SYNC_STEP=1; advance = step when SYNC_STEP=0.
REQ-017 With SYNC_STEP=1, a step rise meeting setup produces exactly one advance, and count changes on the 3rd rising clock edge after the rise.
- Each press gives one advance regardless of how long step is held high.
REQ-018 Priority, highest first:
- clear: count is set to 0.
- load: count is set to min(load_value, MODULUS-1).
- advance: count steps as below.
- otherwise: count holds.
REQ-019 Up with count < MODULUS-1 increments count by 1.
- Down with count > 0 decrements count by 1.
REQ-020 SATURATE=0, up at MODULUS-1: count goes to 0, and wrap and overflow are set.
- SATURATE=0, down at 0: count goes to MODULUS-1, and wrap and overflow are set.
REQ-021 SATURATE=1 at a limit: count holds, wrap stays 0, and overflow is set.
REQ-022 Terminal value is MODULUS-1 when up=1 and 0 when up=0.
- carry is high only in a cycle where advance=1 and count equals the terminal value.
REQ-023 A direction change takes effect on the same edge as a concurrent advance.
REQ-024 overflow stays set until clear or reset.
- load does not affect overflow.
REQ-025 clear and load arriving with advance in the same cycle suppress the advance, including its wrap and overflow.
REQ-026 Next-state arithmetic is computed at WIDTH+1 bits, so MODULUS=2**WIDTH causes no truncation error.

Reset
REQ-027 reset low asynchronously forces count=0, wrap=0, overflow=0, and clears the synchroniser and edge-detect flops.
REQ-028 Reset release is synchronous to clock.
- A step level already high at release produces no advance.
REQ-029 Reset in the middle of a count or a held press abandons that operation; no pending advance survives.

Structure
REQ-030 A shared package holds MODULUS range-check constants and the direction encoding (UP=1, DOWN=0).
REQ-031 Sub-module pulse_sync holds the 2-flop synchroniser plus a rising-edge detector with one-cycle pulse output.
- It is instantiated only when SYNC_STEP=1.
REQ-032 An illegal MODULUS is a parameter-check error at elaboration.

Verification (WIDTH=4, MODULUS=10)
REQ-033 Up wrap: 10 step presses from reset with up=1 -> count 1..9 then 0; wrap pulses once; overflow=1.
REQ-034 Down wrap: from 0 with up=0, 1 press -> count=9, wrap pulse, carry high in the advance cycle.
REQ-035 Load: load_value=13 -> count=9; load=1 and clear=1 together -> count=0; load=1 with advance -> count=load value, no step.
REQ-036 Saturate: SATURATE=1, count=9, up, 3 presses -> count stays 9, wrap never set, overflow=1.
REQ-037 Step held high for 50 cycles -> exactly one increment, on the 3rd edge after the rise.
- SYNC_STEP=0 with step high for 5 cycles -> 5 increments.
REQ-038 Reset mid-press: step high, reset low for 2 cycles, release with step still high -> count=0, no advance, overflow=0.
